// File: rtl/control_suma_bcd_if.sv
// Keypad-event and result bus of the BCD calculator sequencer.
// master: keypad side; drives tecla_valida/tecla, observes operands, sum and status.
// slave : sequencer side; consumes key events, drives operands, sum, display and status.
//   tecla_valida  one-cycle key event strobe
//   tecla         key code (0-9 digit, A guardar, B borrar, C-F ignored)
//   numero_a/b    captured operands, packed BCD, digit 0 in [3:0]
//   resultado     BCD sum, top digit is the carry digit
//   display       value to show
//   estado        0 ENTRADA_A, 1 ENTRADA_B, 2 SUMANDO, 3 RESULTADO
//   ocupado       high while adding
//   listo         one-cycle pulse when resultado becomes final
interface control_suma_bcd_if #(
  parameter int unsigned DIGITS = 4
);
  logic                      tecla_valida;
  logic [3:0]                tecla;
  logic [DIGITS*4-1:0]       numero_a;
  logic [DIGITS*4-1:0]       numero_b;
  logic [(DIGITS+1)*4-1:0]   resultado;
  logic [(DIGITS+1)*4-1:0]   display;
  logic [1:0]                estado;
  logic                      ocupado;
  logic                      listo;

  modport master (
    output tecla_valida, tecla,
    input  numero_a, numero_b, resultado, display, estado, ocupado, listo
  );

  modport slave (
    input  tecla_valida, tecla,
    output numero_a, numero_b, resultado, display, estado, ocupado, listo
  );
endinterface

// File: rtl/control_suma_bcd.sv
// Sequencer for the BCD calculator datapath: builds operands A and B digit by digit from
// keypad events, then runs a digit-serial BCD addition (one digit per clock) and presents
// the (DIGITS+1)-digit sum.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  control_suma_bcd_if.slave (key events in; operands, sum, display, status out)
// Optional feature: define ACUMULAR_EN to let guardar in RESULTADO chain the sum (when it
// has no carry digit) into operand A and continue with operand B entry.
module control_suma_bcd #(
  parameter int unsigned DIGITS = 4
) (
  input logic                clk,
  input logic                rst,
  control_suma_bcd_if.slave  bus
);

  localparam int unsigned NumW = DIGITS * 4;
  localparam int unsigned ResW = (DIGITS + 1) * 4;
  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DIGITS);
  localparam logic [CntW-1:0] IdxLast = CntW'(DIGITS - 1);

  typedef enum logic [1:0] {
    StEntradaA  = 2'd0,
    StEntradaB  = 2'd1,
    StSumando   = 2'd2,
    StResultado = 2'd3
  } estado_e;

  estado_e           r_estado;
  logic [NumW-1:0]   r_entrada;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   r_idx;
  logic              r_carry;
  logic [NumW-1:0]   r_numero_a;
  logic [NumW-1:0]   r_numero_b;
  logic [ResW-1:0]   r_resultado;
  logic [ResW-1:0]   r_display;
  logic              r_ocupado;
  logic              r_listo;

  estado_e           w_estado_d;
  logic [NumW-1:0]   w_entrada_d;
  logic [CntW-1:0]   w_cnt_d;
  logic [CntW-1:0]   w_idx_d;
  logic              w_carry_d;
  logic [NumW-1:0]   w_numero_a_d;
  logic [NumW-1:0]   w_numero_b_d;
  logic [ResW-1:0]   w_resultado_d;
  logic [ResW-1:0]   w_display_d;
  logic              w_listo_d;

  logic              w_digito_key;
  logic              w_guardar;
  logic              w_borrar;
  logic [4:0]        w_suma;
  logic [3:0]        w_digito;
  logic              w_carry_sig;

  assign w_digito_key = bus.tecla_valida && (bus.tecla <= 4'd9);
  assign w_guardar    = bus.tecla_valida && (bus.tecla == 4'hA);
  assign w_borrar     = bus.tecla_valida && (bus.tecla == 4'hB);

  // One BCD digit of the serial adder; idx never exceeds DIGITS-1 so the selects stay in range.
  assign w_suma      = {1'b0, r_numero_a[4*r_idx +: 4]} + {1'b0, r_numero_b[4*r_idx +: 4]}
                     + {4'd0, r_carry};
  assign w_carry_sig = (w_suma > 5'd9);
  assign w_digito    = w_carry_sig ? (w_suma[3:0] + 4'd6) : w_suma[3:0];

  always_comb begin
    w_estado_d    = r_estado;
    w_entrada_d   = r_entrada;
    w_cnt_d       = r_cnt;
    w_idx_d       = r_idx;
    w_carry_d     = r_carry;
    w_numero_a_d  = r_numero_a;
    w_numero_b_d  = r_numero_b;
    w_resultado_d = r_resultado;
    w_listo_d     = 1'b0;

    unique case (r_estado)
      StEntradaA, StEntradaB: begin
        if (w_digito_key) begin
          if (r_cnt < CntMax) begin
            w_entrada_d = {r_entrada[NumW-5:0], bus.tecla};
            w_cnt_d     = r_cnt + CntW'(1);
          end
        end else if (w_guardar) begin
          w_entrada_d = '0;
          w_cnt_d     = '0;
          if (r_estado == StEntradaA) begin
            w_numero_a_d = r_entrada;
            w_estado_d   = StEntradaB;
          end else begin
            w_numero_b_d  = r_entrada;
            w_idx_d       = '0;
            w_carry_d     = 1'b0;
            w_resultado_d = '0;
            w_estado_d    = StSumando;
          end
        end else if (w_borrar) begin
          w_numero_a_d  = '0;
          w_numero_b_d  = '0;
          w_resultado_d = '0;
          w_entrada_d   = '0;
          w_cnt_d       = '0;
          w_estado_d    = StEntradaA;
        end
      end

      StSumando: begin
        // Keys are deliberately not decoded here.
        w_resultado_d[4*r_idx +: 4] = w_digito;
        w_carry_d = w_carry_sig;
        if (r_idx == IdxLast) begin
          w_resultado_d[ResW-1 -: 4] = {3'b000, w_carry_sig};
          w_idx_d    = '0;
          w_listo_d  = 1'b1;
          w_estado_d = StResultado;
        end else begin
          w_idx_d = r_idx + CntW'(1);
        end
      end

      StResultado: begin
        if (w_digito_key) begin
          w_numero_a_d  = '0;
          w_numero_b_d  = '0;
          w_resultado_d = '0;
          w_entrada_d   = {{(NumW-4){1'b0}}, bus.tecla};
          w_cnt_d       = CntW'(1);
          w_estado_d    = StEntradaA;
        end else if (w_borrar) begin
          w_numero_a_d  = '0;
          w_numero_b_d  = '0;
          w_resultado_d = '0;
          w_entrada_d   = '0;
          w_cnt_d       = '0;
          w_estado_d    = StEntradaA;
        end
`ifdef ACUMULAR_EN
        // A sum with a carry digit does not fit in operand A, so it cannot be chained.
        else if (w_guardar && (r_resultado[ResW-1 -: 4] == 4'd0)) begin
          w_numero_a_d = r_resultado[NumW-1:0];
          w_numero_b_d = '0;
          w_entrada_d  = '0;
          w_cnt_d      = '0;
          w_estado_d   = StEntradaB;
        end
`endif
      end

      default: w_estado_d = StEntradaA;
    endcase

    // Display tracks next-state values so it lines up with estado.
    if ((w_estado_d == StEntradaA) || (w_estado_d == StEntradaB)) begin
      w_display_d = {4'h0, w_entrada_d};
    end else begin
      w_display_d = w_resultado_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado    <= StEntradaA;
      r_entrada   <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_numero_a  <= '0;
      r_numero_b  <= '0;
      r_resultado <= '0;
      r_display   <= '0;
      r_ocupado   <= 1'b0;
      r_listo     <= 1'b0;
    end else begin
      r_estado    <= w_estado_d;
      r_entrada   <= w_entrada_d;
      r_cnt       <= w_cnt_d;
      r_idx       <= w_idx_d;
      r_carry     <= w_carry_d;
      r_numero_a  <= w_numero_a_d;
      r_numero_b  <= w_numero_b_d;
      r_resultado <= w_resultado_d;
      r_display   <= w_display_d;
      r_ocupado   <= (w_estado_d == StSumando);
      r_listo     <= w_listo_d;
    end
  end

  assign bus.numero_a  = r_numero_a;
  assign bus.numero_b  = r_numero_b;
  assign bus.resultado = r_resultado;
  assign bus.display   = r_display;
  assign bus.estado    = r_estado;
  assign bus.ocupado   = r_ocupado;
  assign bus.listo     = r_listo;

endmodule

// File: tb/tb_control_suma_bcd.sv
// Self-checking bench for control_suma_bcd (DIGITS=4): table of key sequences with expected
// operands and sums, a scoreboard queue of expected sums, and hand-written corner sequences.
module tb_control_suma_bcd;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb_q[$];

  typedef struct {
    logic [39:0] keys;   // first key in the most significant used nibble
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] res;
  } vec_t;

  vec_t vecs[7];

  control_suma_bcd_if #(.DIGITS(4)) bus ();

  control_suma_bcd #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle key pulse; returns on the negedge after the capturing posedge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    bus.tecla        = k;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    bus.tecla        = 4'h0;
  endtask

  // Waits (bounded) for listo, then pops the expected sum from the scoreboard.
  task automatic wait_result(input int exp_busy);
    int          busy;
    bit          got;
    logic [19:0] exp;
    busy = 0;
    got  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.listo) begin
        got = 1'b1;
        break;
      end
      if (bus.ocupado) busy++;
      @(negedge clk);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 20'hFFFFF;
    check("listo_seen", 32'(got), 32'd1);
    check("ocupado_cycles", 32'(busy), 32'(exp_busy));
    check("resultado", 32'(bus.resultado), 32'(exp));
    check("display_res", 32'(bus.display), 32'(exp));
    check("estado_res", 32'(bus.estado), 32'd3);
    check("ocupado_off", 32'(bus.ocupado), 32'd0);
    @(negedge clk);
    check("listo_pulse", 32'(bus.listo), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v);
    sb_q.push_back(v.res);
    for (int i = 0; i < v.n; i++) begin
      press(v.keys[(v.n-1-i)*4 +: 4]);
    end
    wait_result(4);
    check("numero_a", 32'(bus.numero_a), 32'(v.a));
    check("numero_b", 32'(bus.numero_b), 32'(v.b));
  endtask

  initial begin
    vecs[0] = '{40'h1234A5678A, 10, 16'h1234, 16'h5678, 20'h06912};
    vecs[1] = '{40'h9999A0001A, 10, 16'h9999, 16'h0001, 20'h10000};
    vecs[2] = '{40'h0000A0A,     7, 16'h0000, 16'h0000, 20'h00000};
    vecs[3] = '{40'h5A5A,        4, 16'h0005, 16'h0005, 20'h00010};
    vecs[4] = '{40'h9999A9999A, 10, 16'h9999, 16'h9999, 20'h19998};
    vecs[5] = '{40'h12345A1A,    8, 16'h1234, 16'h0001, 20'h01235};
    vecs[6] = '{40'h1C2A3FA,     7, 16'h0012, 16'h0003, 20'h00015};

    rst              = 1'b0;
    bus.tecla_valida = 1'b0;
    bus.tecla        = 4'h0;
    #3;
    check("rst_estado", 32'(bus.estado), 32'd0);
    check("rst_display", 32'(bus.display), 32'd0);
    check("rst_resultado", 32'(bus.resultado), 32'd0);
    check("rst_numero_a", 32'(bus.numero_a), 32'd0);
    check("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check("rst_listo", 32'(bus.listo), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      apply_vec(vecs[v]);
    end

    // Fifth digit dropped, capture A, then borrar clears everything.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check("overflow_display", 32'(bus.display), 32'h01234);
    press(4'hA);
    check("cap_a_estado", 32'(bus.estado), 32'd1);
    check("cap_a_numero_a", 32'(bus.numero_a), 32'h1234);
    check("cap_a_display", 32'(bus.display), 32'd0);
    press(4'hB);
    check("borrar_estado", 32'(bus.estado), 32'd0);
    check("borrar_numero_a", 32'(bus.numero_a), 32'd0);
    check("borrar_display", 32'(bus.display), 32'd0);

    // Keys during SUMANDO are ignored.
    sb_q.push_back(20'h06912);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hA);
    bus.tecla_valida = 1'b1;
    bus.tecla        = 4'h7;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    bus.tecla        = 4'hB;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    bus.tecla        = 4'h0;
    wait_result(1);
    press(4'h3);
    check("restart_estado", 32'(bus.estado), 32'd0);
    check("restart_display", 32'(bus.display), 32'h00003);
    check("restart_numero_a", 32'(bus.numero_a), 32'd0);
    check("restart_numero_b", 32'(bus.numero_b), 32'd0);
    press(4'hB);

    // Asynchronous reset between edges during SUMANDO.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hA);
    check("sumando_estado", 32'(bus.estado), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_estado", 32'(bus.estado), 32'd0);
    check("arst_display", 32'(bus.display), 32'd0);
    check("arst_numero_a", 32'(bus.numero_a), 32'd0);
    check("arst_numero_b", 32'(bus.numero_b), 32'd0);
    check("arst_resultado", 32'(bus.resultado), 32'd0);
    check("arst_ocupado", 32'(bus.ocupado), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_vec(vecs[0]);

`ifdef ACUMULAR_EN
    press(4'hA);
    check("chain_numero_a", 32'(bus.numero_a), 32'h6912);
    check("chain_estado", 32'(bus.estado), 32'd1);
    sb_q.push_back(20'h06913);
    press(4'h1);
    press(4'hA);
    wait_result(4);
    check("chain_numero_b", 32'(bus.numero_b), 32'h0001);
`else
    press(4'hA);
    check("guardar_res_estado", 32'(bus.estado), 32'd3);
    check("guardar_res_numero_a", 32'(bus.numero_a), 32'h1234);
    check("guardar_res_resultado", 32'(bus.resultado), 32'h06912);
`endif
    press(4'hE);
    check("ignored_code_estado", 32'(bus.estado), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
